// File: rtl/updown_count_ctrl.sv
// -----------------------------------------------------------------------------
// updown_count_ctrl
//
// Sequencer that owns a WIDTH-bit up/down count register and steps it through
// a load / run / pause / terminate sequence under a start/stop/pause command
// interface. Supports one-shot and auto-reload operation between a
// programmable load value and terminal value.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high reset
//   start     in   1      begin a sequence (accepted only in IDLE)
//   stop      in   1      abort the sequence (RUN and PAUSE)
//   pause     in   1      level; holds the count while high in RUN/PAUSE
//   dir       in   1      0 = up, 1 = down (captured at start)
//   mode      in   1      0 = one-shot, 1 = auto-reload (captured at start)
//   load_val  in   WIDTH  initial / reload value (captured at start)
//   term_val  in   WIDTH  terminal value (captured at start)
//   count     out  WIDTH  registered counter value
//   busy      out  1      high in RUN or PAUSE
//   tc        out  1      one cycle per terminal hit
//   done      out  1      one-cycle pulse on one-shot completion
// -----------------------------------------------------------------------------
module updown_count_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             dir,
   input  logic             mode,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] term_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;

   // Shadow copies of the sequence parameters, frozen at an accepted start.
   logic             dir_q,  dir_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] load_q, load_d;
   logic [WIDTH-1:0] term_q, term_d;

   logic             at_term;

   assign at_term = (count_q == term_q);

   // Next-state and datapath logic.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_d = state_q;
      count_d = count_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      load_d  = load_q;
      term_d  = term_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               dir_d   = dir;
               mode_d  = mode;
               load_d  = load_val;
               term_d  = term_val;
               count_d = load_val;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (pause) begin
               state_d = ST_PAUSE;
            end else if (at_term) begin
               if (mode_q) count_d = load_q;
               else        state_d = ST_DONE;
            end else if (dir_q) begin
               count_d = count_q - 1'b1;   // wraps modulo 2^WIDTH
            end else begin
               count_d = count_q + 1'b1;
            end
         end

         ST_PAUSE: begin
            if (stop)        state_d = ST_IDLE;
            else if (!pause) state_d = ST_RUN;
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State, count and shadow registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge value; blocking here would create ordering races.
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         dir_q   <= 1'b0;
         mode_q  <= 1'b0;
         load_q  <= '0;
         term_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         load_q  <= load_d;
         term_q  <= term_d;
      end
   end

   // Output decodes. tc is masked by stop/pause because neither a reload nor a
   // terminal transition happens in a cycle where those take priority.
   assign count = count_q;
   assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign tc    = (state_q == ST_RUN) && !stop && !pause && at_term;
   assign done  = (state_q == ST_DONE);

endmodule
